corr_tx_scheduler: RTL and testbench

//  Shares one hex-ASCII UART byte stream among CHANNELS correlator result words.

---
 rtl/corr_tx_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/corr_tx_scheduler.sv | 113 +++++++++++
 tb/tb_corr_tx_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/corr_tx_pkg.sv
// Shared types and ASCII helpers for the correlator hex-UART scheduler.
package corr_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND_ID,
    SEND_NIB,
    SEND_CR
  } state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  // Upper-case hex digit for one nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return ASCII_0 + {4'h0, n};
    else           return ASCII_A + {4'h0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester strictly after the last-granted pointer wins.
module rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int IW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IW-1:0]       pointer,
  output logic [CHANNELS-1:0] grant,
  output logic [IW-1:0]       index,
  output logic                any
);

  int c;

  // Scan from pointer+1 around to pointer itself so the last winner ranks lowest.
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    c     = 0;
    for (int k = 1; k <= CHANNELS; k++) begin
      c = (int'(pointer) + k) % CHANNELS;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        index    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/corr_tx_scheduler.sv
// Serialises correlator result words from several channels onto one UART byte
// stream as "<id><hex nibbles MSB first><CR>", granting channels round-robin.
module corr_tx_scheduler
  import corr_tx_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int RESOLUTION = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [CHANNELS-1:0]            req,
  input  logic [CHANNELS*RESOLUTION-1:0] data,
  output logic [CHANNELS-1:0]            ack,
  output logic [7:0]                     tx_byte,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic                           busy
);

  localparam int NIBBLES = RESOLUTION / 4;
  localparam int IW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t                state, next_state;
  logic [RESOLUTION-1:0] word;
  logic [NW-1:0]         nib;
  logic [NW-1:0]         nib_dec;
  logic [IW-1:0]         pointer;
  logic [CHANNELS-1:0]   grant;
  logic [IW-1:0]         grant_idx;
  logic                  grant_any;
  logic                  start;
  logic                  xfer;

  rr_arbiter #(
    .CHANNELS(CHANNELS),
    .IW      (IW)
  ) u_arbiter (
    .req    (req),
    .pointer(pointer),
    .grant  (grant),
    .index  (grant_idx),
    .any    (grant_any)
  );

  assign xfer    = tx_valid & tx_ready;
  assign busy    = (state != IDLE);
  assign nib_dec = nib - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (enable && grant_any) begin
          start      = 1'b1;
          next_state = SEND_ID;
        end
      end
      SEND_ID:  if (xfer) next_state = SEND_NIB;
      SEND_NIB: if (xfer && nib == '0) next_state = SEND_CR;
      SEND_CR:  if (xfer) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // nib always names the nibble currently presented on tx_byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word     <= '0;
      nib      <= '0;
      pointer  <= IW'(CHANNELS - 1);
      ack      <= '0;
      tx_byte  <= '0;
      tx_valid <= 1'b0;
    end else begin
      ack <= start ? grant : '0;
      if (start) begin
        word     <= data[int'(grant_idx)*RESOLUTION +: RESOLUTION];
        pointer  <= grant_idx;
        tx_byte  <= hex_char(4'(grant_idx));
        tx_valid <= 1'b1;
      end else if (xfer) begin
        case (state)
          SEND_ID: begin
            tx_byte <= hex_char(word[RESOLUTION-1 -: 4]);
            nib     <= NW'(NIBBLES - 1);
          end
          SEND_NIB: begin
            if (nib == '0) begin
              tx_byte <= ASCII_CR;
            end else begin
              nib     <= nib_dec;
              tx_byte <= hex_char(word[{nib_dec, 2'b00} +: 4]);
            end
          end
          SEND_CR: begin
            tx_byte  <= '0;
            tx_valid <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_corr_tx_scheduler.sv
// Self-checking bench for corr_tx_scheduler: directed table, corner sequences,
// and random traffic against a message-queue reference model.
module tb_corr_tx_scheduler;

  localparam int CH  = 4;
  localparam int RES = 32;
  localparam int NIB = RES / 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [CH-1:0]     req;
  logic [CH*RES-1:0] data;
  logic [CH-1:0]     ack;
  logic [7:0]        tx_byte;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;

  corr_tx_scheduler #(
    .CHANNELS  (CH),
    .RESOLUTION(RES)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .req     (req),
    .data    (data),
    .ack     (ack),
    .tx_byte (tx_byte),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: the bytes still owed for the message in flight.
  logic [7:0]    m_q[$];
  int            m_ptr;
  logic [CH-1:0] m_ack;
  logic [7:0]    rx[$];
  int            order[$];
  logic [7:0]    exp_msg[$];

  typedef struct {
    logic [CH-1:0] req;
    logic          en;
    logic          rdy;
    logic [CH-1:0] ack;
    logic          valid;
    logic [7:0]    tx;
    logic          busy;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [7:0] hexc(input int n);
    string s;
    s = "0123456789ABCDEF";
    return s[n];
  endfunction

  function automatic int first_bit(input logic [CH-1:0] v);
    for (int i = 0; i < CH; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build_msg(input int ch, input logic [RES-1:0] w);
    exp_msg.delete();
    exp_msg.push_back(hexc(ch));
    for (int n = NIB - 1; n >= 0; n--) exp_msg.push_back(hexc(int'(w[n*4 +: 4])));
    exp_msg.push_back(8'h0D);
  endtask

  task automatic model_edge();
    int w;
    m_ack = '0;
    if (m_q.size() > 0) begin
      if (tx_ready) void'(m_q.pop_front());
    end else if (enable && req != '0) begin
      w = 0;
      for (int k = 1; k <= CH; k++) begin
        if (req[(m_ptr + k) % CH]) begin
          w = (m_ptr + k) % CH;
          break;
        end
      end
      build_msg(w, data[w*RES +: RES]);
      foreach (exp_msg[i]) m_q.push_back(exp_msg[i]);
      m_ack[w] = 1'b1;
      m_ptr    = w;
    end
  endtask

  task automatic check_output();
    check("model_ack", 32'(ack), 32'(m_ack));
    check("model_valid", 32'(tx_valid), 32'(m_q.size() > 0));
    check("model_busy", 32'(busy), 32'(m_q.size() > 0));
    if (m_q.size() > 0) check("model_byte", 32'(tx_byte), 32'(m_q[0]));
  endtask

  task automatic step();
    if (tx_valid && tx_ready) rx.push_back(tx_byte);
    @(posedge clk);
    model_edge();
    #1;
    check_output();
  endtask

  task automatic apply_stimulus(input logic [CH-1:0] r, input logic en, input logic rdy);
    req      = r;
    enable   = en;
    tx_ready = rdy;
    step();
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    m_q.delete();
    m_ptr = CH - 1;
    m_ack = '0;
    check("rst_ack", 32'(ack), 0);
    check("rst_valid", 32'(tx_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_byte", 32'(tx_byte), 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rx.delete();
  endtask

  task automatic do_reset();
    assert_reset();
    release_reset();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] held;
    int ch3_acks;

    rst_n    = 1'b0;
    enable   = 1'b1;
    req      = '0;
    tx_ready = 1'b1;
    data     = '0;

    // Single message from ch2, one record per clock.
    tbl[0]  = '{4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 8'h32, 1'b1};
    tbl[1]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 8'h31, 1'b1};
    tbl[2]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 8'h32, 1'b1};
    tbl[3]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 8'h33, 1'b1};
    tbl[4]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 8'h34, 1'b1};
    tbl[5]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 8'h41, 1'b1};
    tbl[6]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 8'h42, 1'b1};
    tbl[7]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 8'h43, 1'b1};
    tbl[8]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 8'h44, 1'b1};
    tbl[9]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 8'h0D, 1'b1};
    tbl[10] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0};
    tbl[11] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0};

    #12;
    do_reset();
    data[2*RES +: RES] = 32'h1234ABCD;
    foreach (tbl[i]) begin
      apply_stimulus(tbl[i].req, tbl[i].en, tbl[i].rdy);
      check("t1_ack", 32'(ack), 32'(tbl[i].ack));
      check("t1_valid", 32'(tx_valid), 32'(tbl[i].valid));
      check("t1_busy", 32'(busy), 32'(tbl[i].busy));
      if (tbl[i].valid) check("t1_byte", 32'(tx_byte), 32'(tbl[i].tx));
    end
    check("t1_count", rx.size(), 10);

    // All four channels requesting: strict rotation from ch0.
    do_reset();
    order.delete();
    for (int cyc = 0; cyc < 100 && order.size() < 5; cyc++) begin
      apply_stimulus(4'hF, 1'b1, 1'b1);
      if (ack != '0) begin
        check("t2_onehot", $countones(ack), 1);
        order.push_back(first_bit(ack));
      end
    end
    check("t2_grants", order.size(), 5);
    for (int i = 0; i < order.size() && i < 5; i++) check("t2_order", order[i], i % CH);

    // Back-pressure on the third byte.
    do_reset();
    data[0 +: RES] = 32'hCAFE0123;
    apply_stimulus(4'b0001, 1'b1, 1'b1);
    check("t3_ack", 32'(ack), 32'h1);
    for (int cyc = 0; cyc < 10 && rx.size() < 2; cyc++) apply_stimulus('0, 1'b1, 1'b1);
    held = tx_byte;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus('0, 1'b1, 1'b0);
      check("t3_stall_byte", 32'(tx_byte), 32'(held));
      check("t3_stall_valid", 32'(tx_valid), 1);
    end
    for (int cyc = 0; cyc < 20 && busy; cyc++) apply_stimulus('0, 1'b1, 1'b1);
    build_msg(0, 32'hCAFE0123);
    check("t3_count", rx.size(), 10);
    for (int i = 0; i < rx.size() && i < 10; i++) check("t3_byte", 32'(rx[i]), 32'(exp_msg[i]));

    // enable dropped mid-message: message completes, no new grant until re-enabled.
    do_reset();
    apply_stimulus(4'b0010, 1'b1, 1'b1);
    check("t4_first", 32'(ack), 32'h2);
    for (int cyc = 0; cyc < 10 && rx.size() < 3; cyc++) apply_stimulus(4'hF, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(4'hF, 1'b0, 1'b1);
      check("t4_no_ack", 32'(ack), 0);
    end
    check("t4_count", rx.size(), 10);
    if (rx.size() == 10) check("t4_cr", 32'(rx[9]), 32'h0D);
    apply_stimulus(4'hF, 1'b1, 1'b1);
    check("t4_resume", 32'(ack), 32'h4);

    // Reset in the middle of a message.
    do_reset();
    apply_stimulus(4'hF, 1'b1, 1'b1);
    check("t5_first", 32'(ack), 32'h1);
    req = 4'b1010;
    assert_reset();
    release_reset();
    apply_stimulus(4'b1010, 1'b1, 1'b1);
    check("t5_after", 32'(ack), 32'h2);

    // Word frozen at ack; ch3 drops its request before being served.
    do_reset();
    data[0 +: RES] = 32'hFFFFFFFF;
    apply_stimulus(4'b1001, 1'b1, 1'b1);
    check("t6_ack", 32'(ack), 32'h1);
    data[0 +: RES] = 32'h0;
    ch3_acks = 0;
    for (int i = 0; i < 25; i++) begin
      apply_stimulus(4'b0000, 1'b1, 1'b1);
      if (ack[3]) ch3_acks++;
    end
    check("t6_ch3_acks", ch3_acks, 0);
    build_msg(0, 32'hFFFFFFFF);
    check("t6_count", rx.size(), 10);
    for (int i = 0; i < rx.size() && i < 10; i++) check("t6_byte", 32'(rx[i]), 32'(exp_msg[i]));

    // Random traffic against the model.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      if ($urandom_range(0, 3) == 0) data = {$urandom, $urandom, $urandom, $urandom};
      apply_stimulus(CH'($urandom), ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 70));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
